// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_if
//  Description : Serial pin, byte handshake and status flags of the UART
//                receive framer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if;
    logic       serial_in;
    logic       char_read;
    logic [7:0] data_in;
    logic       char_received;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // master drives the line and the acknowledge; slave is the framer
    modport master (
        output serial_in,
        output char_read,
        input  data_in,
        input  char_received,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  char_read,
        output data_in,
        output char_received,
        output frame_err,
        output overrun,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : 8N1 UART receive framer with 16x oversampling, byte hold
//                register, char_received/char_read handshake, sticky
//                framing and overrun flags.
//  Options     : RX_MAJORITY_EN - 2-of-3 majority vote around each mid-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int TICK_DIV   = 326,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    uart_rx_frame_if.slave    bus
);

    localparam int               c_DIV_W   = $clog2(TICK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       c_MID     = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       c_LAST    = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic                 r_char_read_d;
    logic [c_DIV_W-1:0]   r_div;
    logic [3:0]           r_tcnt;
    logic [2:0]           r_bitcnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_data;
    logic                 r_char_received;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_ack;
    logic [3:0]           w_pt;
    logic                 w_decide;
    logic                 w_bit;

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_div == c_DIV_MAX);
    assign w_ack  = bus.char_read & ~r_char_read_d;

    // Mid-bit tick count: half a bit into START, a full bit in DATA/STOP
    assign w_pt = (r_state == S_START) ? c_MID : c_LAST;

`ifdef RX_MAJORITY_EN
    localparam logic [3:0] c_TCNT_RESTART = 4'd1;

    logic       r_maj_a;
    logic       r_maj_b;
    logic [3:0] w_pt_prev;
    logic [3:0] w_pt_next;
    logic       w_cap_a;
    logic       w_cap_b;

    assign w_pt_prev = w_pt - 4'd1;
    assign w_pt_next = w_pt + 4'd1;
    assign w_cap_a   = w_tick && (r_tcnt == w_pt_prev);
    assign w_cap_b   = w_tick && (r_tcnt == w_pt);
    // Decision lands one tick after mid-bit, using the live sample as third vote
    assign w_decide  = w_tick && (r_tcnt == w_pt_next);
    assign w_bit     = (r_maj_a & r_maj_b) | (r_maj_a & w_rx_s) | (r_maj_b & w_rx_s);
`else
    localparam logic [3:0] c_TCNT_RESTART = 4'd0;

    assign w_decide  = w_tick && (r_tcnt == w_pt);
    assign w_bit     = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_sync          <= 2'b11;
            r_rx_prev       <= 1'b1;
            r_char_read_d   <= 1'b0;
            r_div           <= '0;
            r_tcnt          <= 4'd0;
            r_bitcnt        <= 3'd0;
            r_shift         <= 8'h00;
            r_data          <= 8'h00;
            r_char_received <= 1'b0;
            r_frame_err     <= 1'b0;
            r_overrun       <= 1'b0;
            r_busy          <= 1'b0;
`ifdef RX_MAJORITY_EN
            r_maj_a         <= 1'b1;
            r_maj_b         <= 1'b1;
`endif
        end else begin
            r_sync        <= {r_sync[0], bus.serial_in};
            r_rx_prev     <= w_rx_s;
            r_char_read_d <= bus.char_read;

            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_tcnt <= r_tcnt + 4'd1;
            end

`ifdef RX_MAJORITY_EN
            if (w_cap_a) begin
                r_maj_a <= w_rx_s;
            end
            if (w_cap_b) begin
                r_maj_b <= w_rx_s;
            end
`endif

            // Acknowledge first; a commit or framing error later in this block wins
            if (w_ack) begin
                r_char_received <= 1'b0;
                r_frame_err     <= 1'b0;
                r_overrun       <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_tcnt  <= 4'd0;
                    end
                end

                S_START: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                            r_tcnt   <= c_TCNT_RESTART;
                        end
                    end
                end

                S_DATA: begin
                    if (w_decide) begin
                        r_shift[r_bitcnt] <= w_bit;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            if (!r_char_received || w_ack) begin
                                r_data          <= r_shift;
                                r_char_received <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end

                // Held-low line: wait for idle so a break reports one error only
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_in       = r_data;
    assign bus.char_received = r_char_received;
    assign bus.frame_err     = r_frame_err;
    assign bus.overrun       = r_overrun;
    assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame
//  Description : Scoreboard bench for uart_rx_frame at TICK_DIV=4 (64 clk/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int c_TICK_DIV = 4;
    localparam int c_BIT      = 64;
`ifdef RX_MAJORITY_EN
    localparam int c_COMMIT   = 615;
`else
    localparam int c_COMMIT   = 611;
`endif

    typedef struct {
        logic [7:0] data;
        logic       cr;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_frame_if bus ();

    uart_rx_frame #(
        .TICK_DIV   (c_TICK_DIV),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_cr = 1'b0;
    logic m_fe = 1'b0;
    logic m_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic cr, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.cr = cr; e.fe = fe; e.ov = ov;
        q.push_back(e);
    endtask

    // Monitor: any rising status flag is a DUT event matched against the queue
    always @(negedge clk) begin
        if (!reset && ((bus.char_received && !m_cr) || (bus.frame_err && !m_fe) ||
                       (bus.overrun && !m_ov))) begin
            if (q.size() == 0) begin
                check("event_queue_nonempty", 32'(q.size()), 32'd1);
            end else begin
                m_e = q.pop_front();
                check("ev_data_in",       {24'd0, bus.data_in},       {24'd0, m_e.data});
                check("ev_char_received", {31'd0, bus.char_received}, {31'd0, m_e.cr});
                check("ev_frame_err",     {31'd0, bus.frame_err},     {31'd0, m_e.fe});
                check("ev_overrun",       {31'd0, bus.overrun},       {31'd0, m_e.ov});
            end
        end
        m_cr = bus.char_received;
        m_fe = bus.frame_err;
        m_ov = bus.overrun;
    end

    // Frame starts on the current negedge; optional 4-clk inversion at each mid-bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < c_BIT; i++) begin
                bus.serial_in = (glitch && i >= 31 && i < 35) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        bus.char_read = 1'b1;
        repeat (2) @(negedge clk);
        bus.char_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.serial_in = 1'b1;
        bus.char_read = 1'b0;
        reset         = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_data_in",       {24'd0, bus.data_in},       32'h00);
        check("rst_char_received", {31'd0, bus.char_received}, 32'd0);
        check("rst_frame_err",     {31'd0, bus.frame_err},     32'd0);
        check("rst_overrun",       {31'd0, bus.overrun},       32'd0);
        check("rst_busy",          {31'd0, bus.busy},          32'd0);
        idle(10);

        // 0xA5, with char_received rising one clk after the stop-bit tick
        push_exp(8'hA5, 1'b1, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (c_COMMIT - 1) @(negedge clk);
                check("latency_before_commit", {31'd0, bus.char_received}, 32'd0);
                @(negedge clk);
                check("latency_at_commit", {31'd0, bus.char_received}, 32'd1);
            end
        join
        idle(10);
        ack();
        check("a5_ack_clears", {31'd0, bus.char_received}, 32'd0);

        // Overrun: 0x3C held unacked, 0x81 dropped
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        push_exp(8'h3C, 1'b1, 1'b0, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("ovr_data_kept", {24'd0, bus.data_in}, 32'h3C);
        ack();
        check("ovr_ack_cr", {31'd0, bus.char_received}, 32'd0);
        check("ovr_ack_ov", {31'd0, bus.overrun},       32'd0);

        // Framing error: 0x55 with low stop bit, line held low, then released
        push_exp(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (3 * c_BIT) @(negedge clk);
        check("brk_busy_held", {31'd0, bus.busy}, 32'd1);
        idle(20);
        check("brk_busy_released", {31'd0, bus.busy},          32'd0);
        check("brk_frame_err",     {31'd0, bus.frame_err},     32'd1);
        check("brk_char_received", {31'd0, bus.char_received}, 32'd0);
        ack();
        check("brk_ack_clears", {31'd0, bus.frame_err}, 32'd0);

        // 20-clk low glitch is a false start
        bus.serial_in = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_rise", {31'd0, bus.busy}, 32'd1);
        repeat (10) @(negedge clk);
        idle(100);
        check("glitch_busy_fall", {31'd0, bus.busy},          32'd0);
        check("glitch_no_char",   {31'd0, bus.char_received}, 32'd0);

        // Reset during data bit 4 of 0xFF, then 0x12
        bus.serial_in = 1'b0;
        repeat (c_BIT) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (4 * c_BIT + 32) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_data_in", {24'd0, bus.data_in},       32'h00);
        check("mid_rst_cr",      {31'd0, bus.char_received}, 32'd0);
        check("mid_rst_fe",      {31'd0, bus.frame_err},     32'd0);
        check("mid_rst_ov",      {31'd0, bus.overrun},       32'd0);
        check("mid_rst_busy",    {31'd0, bus.busy},          32'd0);
        idle(20);
        push_exp(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(10);
        ack();

        // Ack edge coincident with the commit of 0x02 while 0x01 is held
        push_exp(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(10);
        fork
            send_frame(8'h02, 1'b1, 1'b0);
            begin
                repeat (c_COMMIT - 1) @(negedge clk);
                bus.char_read = 1'b1;
            end
        join
        bus.char_read = 1'b0;
        check("sim_data_in", {24'd0, bus.data_in},       32'h02);
        check("sim_cr",      {31'd0, bus.char_received}, 32'd1);
        check("sim_ov",      {31'd0, bus.overrun},       32'd0);
        idle(10);
        ack();

`ifdef RX_MAJORITY_EN
        push_exp(8'hC3, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(10);
        ack();
`endif

        idle(10);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
